// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port memory between instruction fetch (IF stage) and
// data access (MEM stage). A data request always wins over a simultaneous
// fetch. While an access is pending or in flight, stall freezes the pipeline.
// An access that runs past TIMEOUT wait cycles is aborted and reported with a
// one-cycle err pulse.
//
// Parameters
//   TIMEOUT    maximum WAIT cycles (counted from 0) before an access aborts
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous, active-low reset
//   if_req     IF stage needs an instruction
//   if_addr    fetch address
//   if_rdata   fetched instruction (held until the next fetch completes)
//   dm_read    MEM stage load
//   dm_write   MEM stage store (wins if dm_read is also high)
//   dm_addr    load/store address
//   dm_wdata   store data
//   dm_rdata   load data (held across stores)
//   mem_req    access strobe, high exactly while in a WAIT state
//   mem_we     write enable for the current access
//   mem_addr   access address, stable for the whole access
//   mem_wdata  write data, stable for the whole access
//   mem_rdata  read data from memory
//   mem_ready  memory completes the access this cycle
//   stall      freeze all pipeline registers (combinational)
//   err        one-cycle pulse after an aborted access
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,

   input  logic        dm_read,
   input  logic        dm_write,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,

   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,

   output logic        stall,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DATA_WAIT = 2'd1,
      INST_WAIT = 2'd2
   } state_t;

   localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

   // Declaration initialisers give the power-up values, so the outputs are
   // already at their reset values before the first reset edge arrives.
   state_t      state       = IDLE;
   state_t      state_next;
   logic [3:0]  wait_cnt    = 4'd0;
   logic        data_served = 1'b0;
   logic        inst_served = 1'b0;
   logic        mem_we_q    = 1'b0;
   logic [31:0] mem_addr_q  = 32'd0;
   logic [31:0] mem_wdata_q = 32'd0;
   logic [31:0] if_rdata_q  = 32'd0;
   logic [31:0] dm_rdata_q  = 32'd0;
   logic        err_q       = 1'b0;

   logic        data_pending;
   logic        inst_pending;
   logic        in_wait;
   logic        timed_out;

   // A requester is pending only until it has been served once; the served
   // flags stop a held request from being replayed while the pipeline is
   // still frozen on the other requester.
   always_comb begin
      data_pending = (dm_read | dm_write) & ~data_served;
      inst_pending = if_req & ~inst_served;
      in_wait      = (state != IDLE);
      timed_out    = in_wait & ~mem_ready & (wait_cnt == TIMEOUT_CNT);
      stall        = data_pending | inst_pending | in_wait;
   end

   // Next-state logic. Data has priority on entry. mem_ready is tested before
   // the timeout, so a completion on the last allowed cycle is a success.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (data_pending) begin
               state_next = DATA_WAIT;
            end else if (inst_pending) begin
               state_next = INST_WAIT;
            end
         end
         DATA_WAIT, INST_WAIT: begin
            if (mem_ready || timed_out) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register and wait counter. The counter sits at zero in IDLE so it
   // is already cleared on the first WAIT cycle, then counts cycles in which
   // the memory has not answered.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
         err_q    <= 1'b0;
      end else begin
         state <= state_next;
         err_q <= timed_out;
         if (!in_wait || mem_ready || timed_out) begin
            wait_cnt <= 4'd0;
         end else begin
            wait_cnt <= wait_cnt + 4'd1;
         end
      end
   end

   // Access registers are captured only when leaving IDLE so address, write
   // enable and write data stay stable for the whole access. A load+store
   // combination becomes a store because mem_we follows dm_write.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_addr_q  <= 32'd0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= 32'd0;
      end else if (state == IDLE) begin
         if (data_pending) begin
            mem_addr_q  <= dm_addr;
            mem_we_q    <= dm_write;
            mem_wdata_q <= dm_wdata;
         end else if (inst_pending) begin
            mem_addr_q  <= if_addr;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 32'd0;
         end
      end
   end

   // Read-data capture. A completed load or fetch takes mem_rdata; an aborted
   // one returns zero. Stores never touch dm_rdata.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if_rdata_q <= 32'd0;
         dm_rdata_q <= 32'd0;
      end else begin
         case (state)
            DATA_WAIT: begin
               if (!mem_we_q) begin
                  if (mem_ready) begin
                     dm_rdata_q <= mem_rdata;
                  end else if (timed_out) begin
                     dm_rdata_q <= 32'd0;
                  end
               end
            end
            INST_WAIT: begin
               if (mem_ready) begin
                  if_rdata_q <= mem_rdata;
               end else if (timed_out) begin
                  if_rdata_q <= 32'd0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Served flags. They set when an access finishes (success or abort) and
   // clear once the pipeline is released, which only happens in IDLE. A flag
   // left over from a request that dropped mid-access is harmless and is
   // cleared the same way.
   always_ff @(posedge clk) begin
      if (!reset) begin
         data_served <= 1'b0;
         inst_served <= 1'b0;
      end else if (!stall) begin
         data_served <= 1'b0;
         inst_served <= 1'b0;
      end else if (mem_ready || timed_out) begin
         if (state == DATA_WAIT) begin
            data_served <= 1'b1;
         end
         if (state == INST_WAIT) begin
            inst_served <= 1'b1;
         end
      end
   end

   // Output drive from the registered state.
   always_comb begin
      mem_req   = in_wait;
      mem_we    = mem_we_q;
      mem_addr  = mem_addr_q;
      mem_wdata = mem_wdata_q;
      if_rdata  = if_rdata_q;
      dm_rdata  = dm_rdata_q;
      err       = err_q;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have these ports, listed as name, direction, width, meaning:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset; synchronous, active-low.
REQ-002 The block SHALL have these fetch-side ports:
- if_req  in  1  IF stage needs an instruction.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetched instruction.
REQ-003 The block SHALL have these data-side ports:
- dm_read  in  1  MEM stage load.
- dm_write  in  1  MEM stage store.
- dm_addr  in  32  load/store address.
- dm_wdata  in  32  store data.
- dm_rdata  out  32  load data.
REQ-004 The block SHALL have these memory-side ports:
- mem_req  out  1  access strobe.
- mem_we  out  1  write enable.
- mem_addr  out  32  access address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data.
- mem_ready  in  1  access complete this cycle.
REQ-005 The block SHALL have these status ports:
- stall  out  1  freeze all pipeline registers.
- err  out  1  one-cycle timeout pulse.
REQ-006 The block SHALL have one parameter, listed as name, default, meaning: TIMEOUT, 15, maximum WAIT cycles before abort.

Function
REQ-007 The block SHALL share one single-port memory between instruction fetch and data access. The FSM states SHALL be IDLE, DATA_WAIT and INST_WAIT.
REQ-008 In IDLE, the FSM SHALL go to DATA_WAIT when (dm_read|dm_write) and data_served=0.
- Otherwise it SHALL go to INST_WAIT when if_req=1 and inst_served=0.
- Otherwise it SHALL stay in IDLE.
- Data SHALL always win a simultaneous request.
REQ-009 On entry to either WAIT state, the block SHALL register mem_addr, mem_we and mem_wdata from the selected requester.
- For DATA: mem_we=dm_write.
- For INST: mem_we=0 and mem_wdata=0.
- These values SHALL stay stable until the WAIT state exits.
REQ-010 mem_req SHALL be 1 exactly while the state is DATA_WAIT or INST_WAIT, and 0 in IDLE.
REQ-011 In a WAIT state with mem_ready=1, the FSM SHALL return to IDLE at the next edge.
- The matching served flag SHALL set.
- On a load, dm_rdata SHALL capture mem_rdata.
- On a fetch, if_rdata SHALL capture mem_rdata.
- On a store, dm_rdata SHALL hold its value.
REQ-012 A 4-bit wait counter SHALL clear on WAIT entry and increment each WAIT cycle without mem_ready.
- At count==TIMEOUT with mem_ready=0, the FSM SHALL abort to IDLE.
- On abort, the served flag SHALL set, the destination rdata SHALL load 0, and err SHALL be 1 for one cycle.
REQ-013 stall SHALL be combinational: ((dm_read|dm_write) & ~data_served) | (if_req & ~inst_served) | (state!=IDLE).
REQ-014 In any cycle with stall=0, data_served and inst_served SHALL clear at the next edge.
REQ-015 Latency with a zero-wait memory (mem_ready=1 in the first WAIT cycle):
- Data-only request: stall=1 for 2 cycles.
- Fetch-only request: stall=1 for 2 cycles.
- Both requests: stall=1 for 4 cycles, with data served first.
REQ-016 If requests drop while a WAIT state is in progress, the access SHALL still complete. Its served flag SHALL then be ignored and cleared when stall goes low.
REQ-017 A simultaneous mem_ready and timeout SHALL count as success.
REQ-018 dm_read and dm_write both high SHALL be treated as a write.

Reset
REQ-019 With reset=0 at a rising edge, the block SHALL set: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, dm_rdata=0, err=0, wait counter=0, both served flags=0.
REQ-020 A reset during a WAIT state SHALL abandon the access without replay.
- mem_req SHALL be 0 in the cycle after the reset edge.
- Requests still asserted after release SHALL be served fresh.
REQ-021 Outputs SHALL also power up to the reset values without a reset edge.

Verification
REQ-022 Fetch only: if_req=1, if_addr=0x40, mem_ready=1 in the first WAIT cycle, mem_rdata=0x00A00093.
- Required: mem_req for 1 cycle at 0x40, if_rdata=0x00A00093, stall high for 2 cycles.
REQ-023 Simultaneous requests: dm_read (addr 0x100) and if_req (addr 0x44).
- Required: the first access is to 0x100 with mem_we=0, the second to 0x44, stall high for 4 cycles.
REQ-024 Store with 3 wait states: dm_write=1, dm_wdata=0xDEADBEEF, addr=0x200, mem_ready on the 4th WAIT cycle.
- Required: mem_addr, mem_we=1 and mem_wdata stable for all 4 cycles; dm_rdata unchanged.
REQ-025 Timeout: dm_read=1, mem_ready held 0.
- Required: err pulse after 16 WAIT cycles, dm_rdata=0, FSM returns to IDLE.
REQ-026 Reset mid-access: reset=0 in the 2nd cycle of INST_WAIT.
- Required: mem_req=0 in the next cycle and all outputs at their reset values; after release, the fetch is reissued.
